// File: rtl/seg7_scan_driver.sv
// Three-digit 7-segment scan driver with a double-buffered display and optional leading-zero blanking.
// seg/an are registered one cycle after digit_sel; load is always accepted and a new value is shown from the next frame boundary.
module seg7_scan_driver #(
   parameter int         DIV      = 4,
   parameter logic [6:0] ZERO_PAT = 7'b0111111
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] H,
   input  logic [6:0] T,
   input  logic [6:0] O,
   input  logic       load,
   input  logic       blank_lz,
   output logic [6:0] seg,
   output logic [2:0] an,
   output logic       frame
);

   localparam int            CW      = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic [1:0] {
      S_ONES  = 2'd0,
      S_TENS  = 2'd1,
      S_HUNDS = 2'd2
   } state_t;

   typedef struct packed {
      logic [6:0] h;
      logic [6:0] t;
      logic [6:0] o;
   } digits_t;

   logic [CW-1:0] cnt;
   logic          tick;
   logic          wrap;
   state_t        digit_sel;
   state_t        digit_nxt;

   digits_t       pend;
   digits_t       disp;
   digits_t       incoming;
   logic          pend_valid;
   logic          active;

   logic          blank_h;
   logic          blank_t;
   logic [2:0]    an_nxt;
   logic [6:0]    seg_nxt;

   assign incoming = '{h: H, t: T, o: O};

   // Prescaler free-runs so slot timing is independent of whether anything is displayed.
   assign tick = (cnt == CNT_MAX);
   assign wrap = tick && (digit_sel == S_HUNDS);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit_sel <= S_ONES;
      end else begin
         digit_sel <= digit_nxt;
      end
   end

   always_comb begin
      digit_nxt = digit_sel;
      if (tick) begin
         case (digit_sel)
            S_ONES:  digit_nxt = S_TENS;
            S_TENS:  digit_nxt = S_HUNDS;
            S_HUNDS: digit_nxt = S_ONES;
            default: digit_nxt = S_ONES;
         endcase
      end
   end

   // Once live, the display only changes at a wrap so a frame never mixes two products;
   // a load landing on the wrap itself goes straight to the display.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend       <= '0;
         disp       <= '0;
         pend_valid <= 1'b0;
         active     <= 1'b0;
      end else if (active) begin
         if (wrap && load) begin
            disp       <= incoming;
            pend_valid <= 1'b0;
         end else if (wrap && pend_valid) begin
            disp       <= pend;
            pend_valid <= 1'b0;
         end else if (load) begin
            pend       <= incoming;
            pend_valid <= 1'b1;
         end
      end else begin
         if (pend_valid) begin
            disp   <= pend;
            active <= 1'b1;
         end
         if (load) begin
            pend       <= incoming;
            pend_valid <= 1'b1;
         end else begin
            pend_valid <= 1'b0;
         end
      end
   end

   // Tens can only be blanked when hundreds is blanked too.
   always_comb begin
      blank_h = blank_lz && (disp.h == ZERO_PAT);
      blank_t = blank_h && (disp.t == ZERO_PAT);
      an_nxt  = 3'b000;
      seg_nxt = 7'b0000000;
      if (active) begin
         case (digit_sel)
            S_ONES: begin
               an_nxt  = 3'b001;
               seg_nxt = disp.o;
            end
            S_TENS: begin
               if (!blank_t) begin
                  an_nxt  = 3'b010;
                  seg_nxt = disp.t;
               end
            end
            S_HUNDS: begin
               if (!blank_h) begin
                  an_nxt  = 3'b100;
                  seg_nxt = disp.h;
               end
            end
            default: begin
               an_nxt  = 3'b000;
               seg_nxt = 7'b0000000;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg   <= '0;
         an    <= '0;
         frame <= 1'b0;
      end else begin
         seg   <= seg_nxt;
         an    <= an_nxt;
         frame <= wrap;
      end
   end

endmodule
